// File: rtl/elastic_buffer_if.sv
// Stream bundle for elastic_buffer: upstream write side, downstream read side,
// occupancy reporting and the FSM debug state.
interface elastic_buffer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  // A word moves on a rising edge where valid and ready are both high. Once
  // raised, valid holds and data stays stable until that edge.
  logic [WIDTH-1:0] i_in_data;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [WIDTH-1:0] o_out_data;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [LW-1:0]    o_level;
  logic             o_almost_full;
  logic             o_dbg_state;

  modport slave (
    input  i_in_data, i_in_valid, i_out_ready,
    output o_in_ready, o_out_data, o_out_valid, o_level, o_almost_full, o_dbg_state
  );

  modport master (
    output i_in_data, i_in_valid, i_out_ready,
    input  o_in_ready, o_out_data, o_out_valid, o_level, o_almost_full, o_dbg_state
  );
endinterface

// File: rtl/elastic_buffer.sv
// DEPTH-word valid/ready elastic buffer: an output register in front of a
// (DEPTH-1)-entry circular RAM, with all outputs registered.
module elastic_buffer #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input logic i_clock,
    input logic i_reset_n,
    input logic i_flush,
    elastic_buffer_if.slave bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int RD = DEPTH - 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(RD - 1);

    typedef enum logic [0:0] {
        ST_STARTUP = 1'b0,
        ST_RUN     = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [LW-1:0]    level_q, level_d;
    logic             afull_q, afull_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [RD];
    logic             mem_we;
    logic             do_in;
    logic             do_out;
    logic             out_free;
    logic             ram_empty;

    // Compare-and-wrap so RAM sizes that are not a power of two work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign do_in     = bus.i_in_valid && in_ready_q;
    assign do_out    = out_valid_q && bus.i_out_ready;
    assign out_free  = !out_valid_q || do_out;
    assign ram_empty = (level_q == LW'(out_valid_q));

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        level_d     = level_q;
        afull_d     = afull_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_we      = 1'b0;
        case (state_q)
            ST_STARTUP: begin
                state_d    = ST_RUN;
                in_ready_d = 1'b1;
            end
            ST_RUN: begin
                if (i_flush) begin
                    level_d     = '0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    out_valid_d = 1'b0;
                    afull_d     = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    // Older RAM words always win the output slot over a new arrival.
                    if (out_free && !ram_empty) begin
                        out_data_d  = mem_q[rd_ptr_q];
                        out_valid_d = 1'b1;
                        rd_ptr_d    = ptr_inc(rd_ptr_q);
                        mem_we      = do_in;
                    end else if (out_free && do_in) begin
                        out_data_d  = bus.i_in_data;
                        out_valid_d = 1'b1;
                    end else if (out_free) begin
                        out_valid_d = 1'b0;
                    end else begin
                        mem_we = do_in;
                    end
                    if (mem_we) begin
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                    end
                    level_d    = level_q + LW'(do_in) - LW'(do_out);
                    in_ready_d = (level_d < LW'(DEPTH));
                    afull_d    = (level_d >= LW'(AFULL_THRESH));
                end
            end
            default: state_d = ST_STARTUP;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_STARTUP;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            level_q     <= '0;
            afull_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            level_q     <= level_d;
            afull_q     <= afull_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.i_in_data;
        end
    end

    assign bus.o_in_ready    = in_ready_q;
    assign bus.o_out_data    = out_data_q;
    assign bus.o_out_valid   = out_valid_q;
    assign bus.o_level       = level_q;
    assign bus.o_almost_full = afull_q;
    assign bus.o_dbg_state   = state_q;
endmodule

// File: tb/tb_elastic_buffer.sv
// Bench for elastic_buffer (DEPTH=4, WIDTH=16): vector table for fill/drain,
// hand sequences for stream, flush and reset, random back-pressure with a scoreboard.
module tb_elastic_buffer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AFULL = DEPTH - 1;

  logic clk;
  logic rst_n;
  logic flush;

  elastic_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ifc ();

  elastic_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_flush   (flush),
    .bus       (ifc.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             ordy;
    logic [WIDTH-1:0] ed;
    logic             erdy;
    logic [2:0]       elvl;
    logic             eov;
    logic             eaf;
  } vec_t;

  vec_t             fill_tbl [10];
  logic [WIDTH-1:0] exp_q [$];
  int               total;
  int               bad;
  int               mdl_level;
  logic             prev_stall;
  logic [WIDTH-1:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sampled at the falling edge: checks state after the last rising edge,
  // then predicts the transfers of the coming rising edge.
  task automatic monitor();
    logic do_in;
    logic do_out;
    if (!rst_n) begin
      prev_stall = 1'b0;
      return;
    end
    chk("level", ifc.o_level, mdl_level);
    chk("afull", ifc.o_almost_full, mdl_level >= AFULL);
    if (prev_stall) begin
      chk("stall_valid", ifc.o_out_valid, 1);
      chk("stall_data", ifc.o_out_data, prev_data);
    end
    prev_stall = ifc.o_out_valid && !ifc.i_out_ready && !flush;
    prev_data  = ifc.o_out_data;
    do_in  = ifc.i_in_valid && ifc.o_in_ready && !flush;
    do_out = ifc.o_out_valid && ifc.i_out_ready;
    if (do_out) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got %0h want none", ifc.o_out_data);
      end else begin
        chk("sb_data", ifc.o_out_data, exp_q.pop_front());
      end
    end
    if (flush) begin
      exp_q.delete();
      mdl_level = 0;
    end else begin
      if (do_in) exp_q.push_back(ifc.i_in_data);
      mdl_level = mdl_level + int'(do_in) - int'(do_out);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    ifc.i_in_valid  = iv;
    ifc.i_in_data   = d;
    ifc.i_out_ready = ordy;
  endtask

  initial begin
    total = 0;
    bad = 0;
    mdl_level = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    flush = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0);

    fill_tbl[0] = '{1'b1, 16'h0001, 1'b0, 16'h0001, 1'b1, 3'd1, 1'b1, 1'b0};
    fill_tbl[1] = '{1'b1, 16'h0002, 1'b0, 16'h0001, 1'b1, 3'd2, 1'b1, 1'b0};
    fill_tbl[2] = '{1'b1, 16'h0003, 1'b0, 16'h0001, 1'b1, 3'd3, 1'b1, 1'b1};
    fill_tbl[3] = '{1'b1, 16'h0004, 1'b0, 16'h0001, 1'b0, 3'd4, 1'b1, 1'b1};
    fill_tbl[4] = '{1'b1, 16'h0005, 1'b0, 16'h0001, 1'b0, 3'd4, 1'b1, 1'b1};
    fill_tbl[5] = '{1'b1, 16'h0005, 1'b1, 16'h0002, 1'b1, 3'd3, 1'b1, 1'b1};
    fill_tbl[6] = '{1'b1, 16'h0005, 1'b1, 16'h0003, 1'b1, 3'd3, 1'b1, 1'b1};
    fill_tbl[7] = '{1'b0, 16'h0005, 1'b1, 16'h0004, 1'b1, 3'd2, 1'b1, 1'b0};
    fill_tbl[8] = '{1'b0, 16'h0005, 1'b1, 16'h0005, 1'b1, 3'd1, 1'b1, 1'b0};
    fill_tbl[9] = '{1'b0, 16'h0005, 1'b1, 16'h0005, 1'b1, 3'd0, 1'b0, 1'b0};

    // reset values, then startup state holds in_ready low until the first edge
    #1;
    chk("rst_out_valid", ifc.o_out_valid, 0);
    chk("rst_out_data", ifc.o_out_data, 0);
    chk("rst_in_ready", ifc.o_in_ready, 0);
    chk("rst_level", ifc.o_level, 0);
    chk("rst_afull", ifc.o_almost_full, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rdy_before_edge", ifc.o_in_ready, 0);
    step();
    chk("rdy_after_release", ifc.o_in_ready, 1);

    // fill to full with the output stalled, then drain through the bubble
    for (int i = 0; i < 10; i++) begin
      drive(fill_tbl[i].iv, fill_tbl[i].d, fill_tbl[i].ordy);
      step();
      chk($sformatf("fill%0d_data", i), ifc.o_out_data, fill_tbl[i].ed);
      chk($sformatf("fill%0d_rdy", i), ifc.o_in_ready, fill_tbl[i].erdy);
      chk($sformatf("fill%0d_level", i), ifc.o_level, fill_tbl[i].elvl);
      chk($sformatf("fill%0d_valid", i), ifc.o_out_valid, fill_tbl[i].eov);
      chk($sformatf("fill%0d_afull", i), ifc.o_almost_full, fill_tbl[i].eaf);
    end

    // streaming at one word per clock
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, WIDTH'(i), 1'b1);
      step();
      chk("stream_valid", ifc.o_out_valid, 1);
      chk("stream_data", ifc.o_out_data, i);
      chk("stream_level", ifc.o_level, 1);
    end
    drive(1'b0, '0, 1'b1);
    step();
    chk("stream_end_level", ifc.o_level, 0);

    // flush at level 3 together with an input word that must be dropped
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'(16'h0010 + i), 1'b0);
      step();
    end
    chk("pre_flush_level", ifc.o_level, 3);
    drive(1'b1, 16'hABCD, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_level", ifc.o_level, 0);
    chk("flush_valid", ifc.o_out_valid, 0);
    chk("flush_rdy", ifc.o_in_ready, 1);
    chk("flush_afull", ifc.o_almost_full, 0);
    chk("flush_data_held", ifc.o_out_data, 16'h0010);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_flush_valid", ifc.o_out_valid, 0);
    end

    // asynchronous reset at level 2, between edges
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, WIDTH'(16'h0021 + i), 1'b0);
      step();
    end
    chk("pre_rst_level", ifc.o_level, 2);
    drive(1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", ifc.o_out_valid, 0);
    chk("arst_data", ifc.o_out_data, 0);
    chk("arst_rdy", ifc.o_in_ready, 0);
    chk("arst_level", ifc.o_level, 0);
    chk("arst_afull", ifc.o_almost_full, 0);
    exp_q.delete();
    mdl_level = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("arst_rdy_release", ifc.o_in_ready, 1);
    drive(1'b1, 16'h0033, 1'b1);
    step();
    chk("arst_first_valid", ifc.o_out_valid, 1);
    chk("arst_first_data", ifc.o_out_data, 16'h0033);
    drive(1'b0, '0, 1'b1);
    step();

    // random back-pressure with occasional flush
    for (int i = 0; i < 4000; i++) begin
      drive(1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      step();
    end
    step();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_level", ifc.o_level, 0);
    chk("drain_valid", ifc.o_out_valid, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
